// File: rtl/mem_arbiter_if.sv
// Core-side request ports and byte-wide memory port for the two-core memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_L = 32,
  parameter int DATA_L = 32
);
  logic              if_re;
  logic [ADDR_L-1:0] if_addr;
  logic [1:0]        if_len;
  logic [DATA_L-1:0] if_rdata;
  logic              if_done;

  logic              ma_re;
  logic              ma_we;
  logic [ADDR_L-1:0] ma_addr;
  logic [1:0]        ma_len;
  logic [DATA_L-1:0] ma_wdata;
  logic [DATA_L-1:0] ma_rdata;
  logic              ma_done;

  logic [ADDR_L-1:0] mem_addr;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;

  modport slave (
    input  if_re, if_addr, if_len,
    output if_rdata, if_done,
    input  ma_re, ma_we, ma_addr, ma_len, ma_wdata,
    output ma_rdata, ma_done,
    output mem_addr, mem_wr, mem_dout,
    input  mem_din
  );

  modport master (
    output if_re, if_addr, if_len,
    input  if_rdata, if_done,
    output ma_re, ma_we, ma_addr, ma_len, ma_wdata,
    input  ma_rdata, ma_done,
    input  mem_addr, mem_wr, mem_dout,
    output mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter serialising fetch and data-port accesses of 1/2/4 bytes
// onto a byte-wide memory with one-cycle read latency.
module mem_arbiter #(
  parameter int ADDR_L = 32,
  parameter int DATA_L = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, LAST, ACK} state_t;

  state_t            state;
  logic [1:0]        k;
  logic [1:0]        last_idx;
  logic              sel_ma;
  logic              op_wr;
  logic [ADDR_L-1:0] addr_lat;
  logic [DATA_L-1:0] wdata_lat;
  logic [DATA_L-1:0] rbuf;

  logic              req_any;
  logic              gnt_ma;
  logic              gnt_wr;
  logic [ADDR_L-1:0] gnt_addr;
  logic [1:0]        gnt_len;

  function automatic logic [1:0] len_to_last(input logic [1:0] len);
    case (len)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [DATA_L-1:0] w, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 4; i++)
      if (idx == i[1:0]) b = w[8*i +: 8];
    return b;
  endfunction

  function automatic logic [DATA_L-1:0] put_byte(input logic [DATA_L-1:0] acc,
                                                 input logic [7:0] b,
                                                 input logic [1:0] idx);
    logic [DATA_L-1:0] r;
    r = acc;
    for (int i = 0; i < 4; i++)
      if (idx == i[1:0]) r[8*i +: 8] = b;
    return r;
  endfunction

  // A simultaneous ma_we/ma_re resolves to a write because gnt_wr only looks at ma_we.
  always_comb begin
    gnt_ma   = bus.ma_we | bus.ma_re;
    gnt_wr   = bus.ma_we;
    req_any  = gnt_ma | bus.if_re;
    gnt_addr = gnt_ma ? bus.ma_addr : bus.if_addr;
    gnt_len  = gnt_ma ? bus.ma_len : bus.if_len;
  end

  // Holding registers: reloaded at every grant, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) begin
      addr_lat  <= gnt_addr;
      wdata_lat <= bus.ma_wdata;
      rbuf      <= '0;
    end else if (state == XFER && !op_wr && k != 2'd0) begin
      rbuf <= put_byte(rbuf, bus.mem_din, k - 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= 2'd0;
      last_idx     <= 2'd0;
      sel_ma       <= 1'b0;
      op_wr        <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wr   <= 1'b0;
      bus.mem_dout <= 8'h00;
      bus.if_done  <= 1'b0;
      bus.ma_done  <= 1'b0;
      bus.if_rdata <= '0;
      bus.ma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            sel_ma       <= gnt_ma;
            op_wr        <= gnt_wr;
            last_idx     <= len_to_last(gnt_len);
            k            <= 2'd0;
            bus.mem_addr <= gnt_addr;
            bus.mem_wr   <= gnt_wr;
            if (gnt_wr) bus.mem_dout <= bus.ma_wdata[7:0];
            state        <= XFER;
          end
        end
        XFER: begin
          k <= k + 2'd1;
          if (k == last_idx) begin
            bus.mem_wr <= 1'b0;
            if (op_wr) begin
              if (sel_ma) bus.ma_done <= 1'b1;
              else        bus.if_done <= 1'b1;
              state <= ACK;
            end else begin
              state <= LAST;
            end
          end else begin
            bus.mem_addr <= addr_lat + ADDR_L'(k + 2'd1);
            if (op_wr) bus.mem_dout <= byte_of(wdata_lat, k + 2'd1);
          end
        end
        LAST: begin
          // The final read byte arrives here and is merged straight into the port register.
          if (sel_ma) begin
            bus.ma_rdata <= put_byte(rbuf, bus.mem_din, last_idx);
            bus.ma_done  <= 1'b1;
          end else begin
            bus.if_rdata <= put_byte(rbuf, bus.mem_din, last_idx);
            bus.if_done  <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          bus.if_done <= 1'b0;
          bus.ma_done <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// contention and mid-transfer reset sequences against a byte memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_L(32), .DATA_L(32)) bus ();

  mem_arbiter #(.ADDR_L(32), .DATA_L(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: fixed ROM contents overlaid by written bytes; the store is
  // folded onto {addr[31], addr[10:0]}, which keeps all addresses used here distinct.
  logic [7:0] wmem [4096];
  logic       wvld [4096];

  function automatic logic [11:0] midx(input logic [31:0] a);
    return {a[31], a[10:0]};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0104: return 8'hA0;
      32'h0000_0006: return 8'hF1;
      32'h0000_0007: return 8'h80;
      32'h0000_0008: return 8'hF2;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      32'h0000_0000: return 8'h33;
      32'h0000_0001: return 8'h44;
      32'h0000_001F: return 8'h66;
      32'h0000_0022: return 8'h77;
      32'h0000_0200: return 8'hEF;
      32'h0000_0201: return 8'hBE;
      32'h0000_0202: return 8'h99;
      32'h0000_0402: return 8'h55;
      32'h0000_0403: return 8'h66;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return wvld[midx(a)] ? wmem[midx(a)] : rom_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) wvld[i] <= 1'b0;
    end else begin
      bus.mem_din <= rd_byte(bus.mem_addr);
      if (bus.mem_wr) begin
        wmem[midx(bus.mem_addr)] <= bus.mem_dout;
        wvld[midx(bus.mem_addr)] <= 1'b1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  task automatic drop_reqs();
    bus.if_re = 1'b0;
    bus.ma_re = 1'b0;
    bus.ma_we = 1'b0;
  endtask

  // One transaction; after the grant edge the request payload is scrambled
  // (request level kept) so the transfer must rely on latched values.
  task automatic run_txn(input logic is_ma, input logic we, input logic re_too,
                         input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata,
                         output int lat, output int wr_cnt, output logic [31:0] rdata,
                         output logic addr_ok, output logic wrong_done);
    int n;
    n = nbytes(len);
    lat = 0; wr_cnt = 0; rdata = '0; addr_ok = 1'b1; wrong_done = 1'b0;
    @(posedge clk); #1;
    if (is_ma) begin
      bus.ma_we = we; bus.ma_re = !we || re_too;
      bus.ma_addr = addr; bus.ma_len = len; bus.ma_wdata = wdata;
    end else begin
      bus.if_re = 1'b1; bus.if_addr = addr; bus.if_len = len;
    end
    @(posedge clk); #1;
    bus.ma_addr = ~bus.ma_addr; bus.ma_len = ~bus.ma_len; bus.ma_wdata = ~bus.ma_wdata;
    bus.if_addr = ~bus.if_addr; bus.if_len = ~bus.if_len;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_wr) wr_cnt++;
      if (c <= n && bus.mem_addr !== addr + 32'(c - 1)) addr_ok = 1'b0;
      if (is_ma ? bus.if_done : bus.ma_done) wrong_done = 1'b1;
      if (is_ma ? bus.ma_done : bus.if_done) begin
        lat = c;
        rdata = is_ma ? bus.ma_rdata : bus.if_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    drop_reqs();
  endtask

  typedef struct {
    logic        is_ma;
    logic        we;
    logic        re_too;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  logic [31:0] exp_if_rd, exp_ma_rd;
  int          lat, wrc;
  logic [31:0] rd;
  logic        aok, wdn;

  initial begin
    //          is_ma we  re2  addr           len    wdata          exp_rdata      lat
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 2'b10, 32'h0,         32'h0000_0013, 6};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 2'b01, 32'hAABB_CCDD, 32'h0,         3};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_001F, 2'b11, 32'h0,         32'h77CC_DD66, 6};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0007, 2'b00, 32'h0,         32'h0000_0080, 3};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 2'b11, 32'h0,         32'h4433_2211, 6};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0200, 2'b01, 32'h0,         32'h0000_BEEF, 4};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 2'b11, 32'h1234_5678, 32'h0,         5};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0300, 2'b10, 32'h0,         32'h1234_5678, 6};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0301, 2'b01, 32'h0,         32'h0000_3456, 4};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0000_BBAA, 32'h0,         3};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b11, 32'h0,         32'h0044_BBAA, 6};
    vt[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0006, 2'b00, 32'h0,         32'h0000_00F1, 3};

    rst = 1'b1; mem_clr = 1'b1;
    drop_reqs();
    bus.if_addr = '0; bus.if_len = '0;
    bus.ma_addr = '0; bus.ma_len = '0; bus.ma_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_wr",   32'(bus.mem_wr),  32'h0);
    check("rst_mem_addr", bus.mem_addr,     32'h0);
    check("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
    check("rst_dones",    32'({bus.if_done, bus.ma_done}), 32'h0);
    check("rst_if_rdata", bus.if_rdata,     32'h0);
    check("rst_ma_rdata", bus.ma_rdata,     32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    exp_if_rd = '0; exp_ma_rd = '0;

    for (int i = 0; i < NV; i++) begin
      run_txn(vt[i].is_ma, vt[i].we, vt[i].re_too, vt[i].addr, vt[i].len, vt[i].wdata,
              lat, wrc, rd, aok, wdn);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("v%0d_other_done", i), 32'(wdn), 32'h0);
      check($sformatf("v%0d_write_count", i), 32'(wrc), vt[i].we ? 32'(nbytes(vt[i].len)) : 32'h0);
      check($sformatf("v%0d_addr_seq", i), 32'(aok), 32'h1);
      if (!vt[i].we) begin
        check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
        if (vt[i].is_ma) exp_ma_rd = vt[i].exp_rdata;
        else             exp_if_rd = vt[i].exp_rdata;
      end
      @(negedge clk);
      check($sformatf("v%0d_done_cleared", i), 32'({bus.if_done, bus.ma_done}), 32'h0);
      check($sformatf("v%0d_if_rdata_hold", i), bus.if_rdata, exp_if_rd);
      check($sformatf("v%0d_ma_rdata_hold", i), bus.ma_rdata, exp_ma_rd);
    end

    // Contention: both reads raised together; data port wins, fetch waits its turn.
    begin
      int ma_c, if_c;
      logic [31:0] addr_at [21];
      ma_c = 0; if_c = 0;
      @(posedge clk); #1;
      bus.ma_re = 1'b1; bus.ma_addr = 32'h7;   bus.ma_len = 2'b00;
      bus.if_re = 1'b1; bus.if_addr = 32'h100; bus.if_len = 2'b10;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        addr_at[c] = bus.mem_addr;
        if (bus.ma_done && ma_c == 0) ma_c = c;
        if (bus.if_done && if_c == 0) if_c = c;
        @(posedge clk); #1;
        if (ma_c == c) bus.ma_re = 1'b0;
        if (if_c == c) begin
          bus.if_re = 1'b0;
          break;
        end
      end
      check("cont_ma_done_cycle", 32'(ma_c), 32'd3);
      check("cont_if_done_cycle", 32'(if_c), 32'd10);
      check("cont_ma_addr", addr_at[1], 32'h7);
      for (int j = 0; j < 4; j++)
        check($sformatf("cont_if_addr%0d", j), addr_at[5 + j], 32'h100 + 32'(j));
      check("cont_ma_rdata", bus.ma_rdata, 32'h0000_0080);
      check("cont_if_rdata", bus.if_rdata, 32'h0000_0013);
    end

    // Reset while the third byte of a 4-byte write is on the bus.
    begin
      logic seen_done;
      seen_done = 1'b0;
      @(posedge clk); #1;
      bus.ma_we = 1'b1; bus.ma_addr = 32'h400; bus.ma_len = 2'b11; bus.ma_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      repeat (3) @(negedge clk);
      check("abort_wr_before", 32'(bus.mem_wr), 32'h1);
      check("abort_addr_before", bus.mem_addr, 32'h402);
      #1 rst = 1'b1;
      #1;
      check("abort_wr_low", 32'(bus.mem_wr), 32'h0);
      check("abort_mem_addr", bus.mem_addr, 32'h0);
      check("abort_ma_rdata", bus.ma_rdata, 32'h0);
      drop_reqs();
      @(posedge clk); #1;
      rst = 1'b0;
      exp_if_rd = '0; exp_ma_rd = '0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.ma_done || bus.if_done) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'h0);
      run_txn(1'b1, 1'b0, 1'b0, 32'h400, 2'b11, 32'h0, lat, wrc, rd, aok, wdn);
      check("after_abort_latency", 32'(lat), 32'd6);
      check("after_abort_rdata", rd, 32'h6655_BEEF);
      check("after_abort_if_rdata", bus.if_rdata, exp_if_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_L, default 32, width of every address.
REQ-002 Parameter DATA_L, default 32, width of core data words.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_re  input  1  fetch-port read request, level, held until if_done.
REQ-006 if_addr  input  ADDR_L  fetch byte address.
REQ-007 if_len  input  2  fetch length code.
REQ-008 if_rdata  output  DATA_L  fetch read data.
REQ-009 if_done  output  1  fetch complete, one-cycle pulse.
REQ-010 ma_re  input  1  data-port read request, level, held until ma_done.
REQ-011 ma_we  input  1  data-port write request, level, held until ma_done.
REQ-012 ma_addr  input  ADDR_L  data-port byte address.
REQ-013 ma_len  input  2  data-port length code.
REQ-014 ma_wdata  input  DATA_L  data-port write data.
REQ-015 ma_rdata  output  DATA_L  data-port read data.
REQ-016 ma_done  output  1  data-port complete, one-cycle pulse.
REQ-017 mem_addr  output  ADDR_L  byte address to memory.
REQ-018 mem_wr  output  1  byte write strobe to memory.
REQ-019 mem_dout  output  8  write byte to memory.
REQ-020 mem_din  input  8  read byte from memory, valid the cycle after its address.

Function
REQ-021 Length code: 00 = 1 byte, 01 = 2 bytes, 10 and 11 = 4 bytes (N).
REQ-022 States: IDLE, XFER, LAST, ACK.
REQ-023 IDLE samples requests each cycle; fixed priority ma_we > ma_re > if_re; ma_we and ma_re both high is treated as a write.
REQ-024 Grant cycle G (IDLE with a request): latch port, op, address, N and write data; go to XFER with byte index k=0.
REQ-025 XFER cycles G+1..G+N: drive mem_addr = latched_addr + k, modulo 2^ADDR_L, and increment k.
REQ-026 Write: mem_wr=1 in XFER; mem_dout = byte k of wdata, little-endian (k=0 is bits 7:0); after byte N-1 go to ACK.
REQ-027 Read: mem_wr=0; the byte returned for address k is captured into bits 8k+7:8k one cycle later; after issuing byte N-1 go to LAST, capture the final byte there, then go to ACK.
REQ-028 Read data is zero-extended; bytes at index N and above are 0.
REQ-029 ACK: pulse the granted port's done for exactly one cycle with rdata stable; return to IDLE.
REQ-030 Read latency, grant to done: N+2 cycles. Write latency: N+1 cycles.
REQ-031 rdata holds its value until the next completion on the same port.
REQ-032 Requests arriving outside IDLE are ignored until IDLE; a port losing priority waits and is not queued.
REQ-033 Core input changes after grant do not affect the transfer in progress.
REQ-034 The core deasserts its request in the cycle after done; IDLE then re-arbitrates.
REQ-035 No alignment restriction; the address may cross any boundary, including wrap from 0xFFFFFFFF to 0.
REQ-036 Outside XFER: mem_wr=0, mem_addr and mem_dout hold their last values.

Reset
REQ-037 rst forces IDLE immediately, asynchronously, including mid-transfer; the aborted transfer produces no done.
REQ-038 Reset values: mem_wr=0, mem_addr=0, mem_dout=0, if_done=0, ma_done=0, if_rdata=0, ma_rdata=0, k=0.

Verification
REQ-039 Fetch: if_re=1, addr=0x100, len=10, memory bytes 0x100..0x103 = 13,00,00,00 -> mem_addr 0x100..0x103 on G+1..G+4, if_done at G+6, if_rdata=0x00000013.
REQ-040 Write: ma_we=1, addr=0x20, len=01, wdata=0xAABBCCDD -> mem_wr on 2 cycles, (0x20,DD), (0x21,CC), ma_done at G+3, no other byte written.
REQ-041 Contention: if_re and ma_re asserted in the same cycle -> ma served first; if_done follows after ma_done, with no overlap on mem_addr.
REQ-042 Byte read: addr=0x7, len=00, byte 0x80 -> ma_rdata=0x00000080, zero-extended.
REQ-043 Wrap: 4-byte read at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-044 Reset pulse during the 3rd byte of a 4-byte write -> mem_wr low at once, no done, state IDLE; the next request completes normally.
